// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if: request/response bundle between the EX stage and the iterative MDU
//   start  : request, taken only while the unit is idle
//   funct3 : RV32M operation select
//   data1  : rs1 operand, data2 : rs2 operand
//   busy   : operation in flight (stall request), done : one-cycle result strobe
//   result : 32-bit result, held until the next accepted request
interface mdu_iterative_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    modport master (output start, funct3, data1, data2, input busy, done, result);
    modport slave (input start, funct3, data1, data2, output busy, done, result);
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mdu_iterative_if slave (start/funct3/data1/data2 in, busy/done/result out)
//   MDU_FAST_MUL_EN : when defined, multiplies use a single-cycle combinational multiplier
module mdu_iterative #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input logic            clk,
    input logic            reset,
    mdu_iterative_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t               state, state_nx;
    logic [2:0]           f3_q;
    logic [31:0]          b_q, result_q, a1, a2, spec_res, imm_res, mres, dres, calc_res, rem_sub;
    logic [63:0]          acc, acc_nx, prod;
    logic [32:0]          mul_sum, div_tmp;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 s1, s2, is_div, special, imm, accept, last, neg_q, neg_r;
`ifdef MDU_FAST_MUL_EN
    logic signed [63:0]   fx1, fx2, fprod;
`endif
    // Operand decode at the accept edge: magnitudes, result signs and one-cycle cases
    always_comb begin
        is_div   = bus.funct3[2];
        s1       = bus.data1[31] & (is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10));
        s2       = bus.data2[31] & (is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01));
        a1       = s1 ? -bus.data1 : bus.data1;
        a2       = s2 ? -bus.data2 : bus.data2;
        special  = is_div & ((bus.data2 == 32'h0) | (~bus.funct3[0] & (bus.data1 == 32'h8000_0000) & (bus.data2 == 32'hFFFF_FFFF)));
        spec_res = (bus.data2 == 32'h0) ? (bus.funct3[1] ? bus.data1 : 32'hFFFF_FFFF)
                                        : (bus.funct3[1] ? 32'h0 : 32'h8000_0000);
`ifdef MDU_FAST_MUL_EN
        fx1      = {{32{s1}}, bus.data1};
        fx2      = {{32{s2}}, bus.data2};
        fprod    = fx1 * fx2;
        imm      = special | ~is_div;
        imm_res  = special ? spec_res : (bus.funct3[1:0] == 2'b00 ? fprod[31:0] : fprod[63:32]);
`else
        imm      = special;
        imm_res  = spec_res;
`endif
        accept   = (state == IDLE) & bus.start;
        last     = cnt == CNT_WIDTH'(DATA_WIDTH - 1);
    end
    // One iteration: multiply adds b into the upper half and shifts right;
    // divide shifts the remainder/quotient pair left and tries a subtraction
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, acc[0] ? b_q : 32'h0};
        div_tmp  = {acc[63:32], acc[31]};
        rem_sub  = div_tmp[31:0] - b_q;
        acc_nx   = f3_q[2] ? ((div_tmp >= {1'b0, b_q}) ? {rem_sub, acc[30:0], 1'b1} : {div_tmp[31:0], acc[30:0], 1'b0})
                           : {mul_sum, acc[31:1]};
        prod     = neg_q ? -acc_nx : acc_nx;
        mres     = (f3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        dres     = f3_q[1] ? (neg_r ? -acc_nx[63:32] : acc_nx[63:32]) : (neg_q ? -acc_nx[31:0] : acc_nx[31:0]);
        calc_res = f3_q[2] ? dres : mres;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? (imm ? FIN : CALC) : IDLE;
            CALC:    state_nx = last ? FIN : CALC;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.busy   = state != IDLE;
        bus.done   = state == FIN;
        bus.result = result_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f3_q     <= 3'b0;
            b_q      <= 32'h0;
            acc      <= 64'h0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result_q <= 32'h0;
        end else if (accept) begin
            f3_q  <= bus.funct3;
            b_q   <= is_div ? a2 : a1;
            acc   <= {32'h0, is_div ? a1 : a2};
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            if (imm) result_q <= imm_res;
            else cnt <= '0;
        end else if (state == CALC) begin
            acc <= acc_nx;
            if (last) result_q <= calc_res;
            else cnt <= cnt + 1'b1;
        end
    end
endmodule
